// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync generation and a test-pattern
// pixel pipeline kept aligned to a fixed-latency external pixel source.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = 8,
  parameter int LAT      = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               enable,
  input  logic [1:0]         pattern_sel,
  output logic               pix_req,
  output logic [10:0]        pix_x,
  output logic [9:0]         pix_y,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_n,
  output logic               VGA_SYNC_n,
  output logic               frame_start,
  output logic [15:0]        frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HL  = 11'(H_TOTAL - 1);
  localparam logic [10:0] BAR = 11'(H_ACTIVE / 8);
  localparam logic [9:0]  VA  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  VL  = 10'(V_TOTAL - 1);

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [1:0]  mode;
    logic [10:0] x;
    logic        y5;
  } tap_t;

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [1:0]  mode_q, mode_d;
  logic        run_q;
  logic        at_org;
  logic        act;
  tap_t        cur;
  tap_t        dl;

  assign at_org = (h_q == '0) && (v_q == '0);
  assign mode_d = at_org ? pattern_sel : mode_q;
  assign act    = enable && RST_N && (h_q < HA) && (v_q < VA);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == HL) begin
      h_d = '0;
      v_d = (v_q == VL) ? '0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 11'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_q    <= '0;
      v_q    <= '0;
      mode_q <= '0;
      run_q  <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      mode_q <= mode_d;
      run_q  <= enable;
    end
  end

  // run_q suppresses the pulse at the origin of the very first frame
  always_comb begin
    cur      = '0;
    cur.act  = act;
    cur.hs   = enable && (h_q >= HS0) && (h_q < HS1);
    cur.vs   = enable && (v_q >= VS0) && (v_q < VS1);
    cur.fs   = enable && at_org && run_q;
    cur.mode = mode_d;
    if (act) begin
      cur.x  = h_q;
      cur.y5 = v_q[5];
    end
  end

  assign pix_req = act;
  assign pix_x   = act ? h_q : '0;
  assign pix_y   = act ? v_q : '0;

  generate
    if (LAT == 0) begin : g_nodl
      assign dl = cur;
    end else begin : g_dl
      tap_t dl_q [LAT];
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
        end else begin
          dl_q[0] <= cur;
          for (int i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign dl = dl_q[LAT-1];
    end
  endgenerate

  logic [10:0]        bar_raw;
  logic [2:0]         bar;
  logic [2:0]         bar_rgb;
  logic               chk;
  logic               m_bar, m_chk, m_ramp;
  logic [COLOR_W-1:0] pr, pg, pb;

  assign bar_raw = dl.x / BAR;
  assign bar     = (bar_raw > 11'd7) ? 3'd7 : bar_raw[2:0];
  assign chk     = dl.x[5] ^ dl.y5;
  assign m_bar   = (dl.mode == 2'd1);
  assign m_chk   = (dl.mode == 2'd2);
  assign m_ramp  = (dl.mode == 2'd3);

  always_comb begin
    bar_rgb = 3'b000;
    unique case (bar)
      3'd0: bar_rgb = 3'b111;
      3'd1: bar_rgb = 3'b110;
      3'd2: bar_rgb = 3'b011;
      3'd3: bar_rgb = 3'b010;
      3'd4: bar_rgb = 3'b101;
      3'd5: bar_rgb = 3'b100;
      3'd6: bar_rgb = 3'b001;
      3'd7: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    pr = pix_r;
    pg = pix_g;
    pb = pix_b;
    unique case (1'b1)
      m_bar: begin
        pr = {COLOR_W{bar_rgb[2]}};
        pg = {COLOR_W{bar_rgb[1]}};
        pb = {COLOR_W{bar_rgb[0]}};
      end
      m_chk: begin
        pr = {COLOR_W{chk}};
        pg = {COLOR_W{chk}};
        pb = {COLOR_W{chk}};
      end
      m_ramp: begin
        pr = dl.x[COLOR_W-1:0];
        pg = dl.x[COLOR_W-1:0];
        pb = dl.x[COLOR_W-1:0];
      end
      default: ;
    endcase
  end

  logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic               hs_q, vs_q, bn_q, fs_q;
  logic               hs_d, vs_d;
  logic [15:0]        fc_q, fc_d;

  always_comb begin
    r_d  = dl.act ? pr : '0;
    g_d  = dl.act ? pg : '0;
    b_d  = dl.act ? pb : '0;
    hs_d = dl.hs ? HS_POL : ~HS_POL;
    vs_d = dl.vs ? VS_POL : ~VS_POL;
    fc_d = fc_q + {15'd0, dl.fs};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      bn_q <= 1'b0;
      fs_q <= 1'b0;
      fc_q <= '0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      bn_q <= dl.act;
      fs_q <= dl.fs;
      fc_q <= fc_d;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_n = bn_q;
  assign VGA_SYNC_n  = 1'b0;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of line timing, patterns, frame
// sequencing, enable and reset on a default and a shrunken raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // default-timing instance
  logic        d_rst_n, d_en;
  logic [1:0]  d_sel;
  logic        d_req;
  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic [7:0]  d_pr, d_pg, d_pb, d_r, d_g, d_b;
  logic        d_hs, d_vs, d_bn, d_sn, d_fs;
  logic [15:0] d_fc;

  vga_timing_gen u_def (
    .CLK(clk), .RST_N(d_rst_n), .enable(d_en), .pattern_sel(d_sel),
    .pix_req(d_req), .pix_x(d_x), .pix_y(d_y),
    .pix_r(d_pr), .pix_g(d_pg), .pix_b(d_pb),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_n(d_bn), .VGA_SYNC_n(d_sn),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  // small raster: 80 x 46 total, 64 x 40 active, frame = 3680 cycles
  logic        s_rst_n, s_en;
  logic [1:0]  s_sel;
  logic        s_req;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic [7:0]  s_pr, s_pg, s_pb, s_r, s_g, s_b;
  logic        s_hs, s_vs, s_bn, s_sn, s_fs;
  logic [15:0] s_fc;

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .LAT(2)
  ) u_small (
    .CLK(clk), .RST_N(s_rst_n), .enable(s_en), .pattern_sel(s_sel),
    .pix_req(s_req), .pix_x(s_x), .pix_y(s_y),
    .pix_r(s_pr), .pix_g(s_pg), .pix_b(s_pb),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_n(s_bn), .VGA_SYNC_n(s_sn),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  // external pixel sources with a two-cycle latency: R=x, G=~x, B=y
  logic [10:0] dx1, dx2, sx1, sx2;
  logic [9:0]  dy1, dy2, sy1, sy2;
  always @(posedge clk) begin
    dx1 <= d_x; dx2 <= dx1; dy1 <= d_y; dy2 <= dy1;
    sx1 <= s_x; sx2 <= sx1; sy1 <= s_y; sy2 <= sy1;
  end
  assign d_pr = dx2[7:0];
  assign d_pg = ~dx2[7:0];
  assign d_pb = dy2[7:0];
  assign s_pr = sx2[7:0];
  assign s_pg = ~sx2[7:0];
  assign s_pb = sy2[7:0];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int fr, lr, fb, lb, fh, lh, bad_x, bad_d, vs_hi, fs_hi, xo;
  int fv, lv, f1, f2, nfs;
  int px [8] = '{0, 99, 100, 199, 200, 650, 799, 800};
  logic [23:0] pe [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                          24'h00FFFF, 24'h0000FF, 24'h000000, 24'h000000};
  logic [7:0] xb;

  initial begin
    d_rst_n = 1'b0; d_en = 1'b1; d_sel = 2'd0;
    s_rst_n = 1'b0; s_en = 1'b1; s_sel = 2'd0;
    repeat (4) @(negedge clk);

    chk("rst_req", d_req, 0);
    chk("rst_blank", d_bn, 0);
    chk("rst_hs", d_hs, 0);
    chk("rst_vs", d_vs, 0);
    chk("rst_rgb", {d_r, d_g, d_b}, 0);
    chk("rst_sync_n", d_sn, 0);
    chk("rst_fs", d_fs, 0);
    chk("rst_fc", d_fc, 0);

    // line 0 at default timing, external mode
    fr = -1; lr = -1; fb = -1; lb = -1; fh = -1; lh = -1;
    bad_x = 0; bad_d = 0; vs_hi = 0;
    d_rst_n = 1'b1;
    for (int c = 0; c < 1060; c++) begin
      #1;
      if (c < 1056) begin
        if (d_req) begin
          if (fr < 0) fr = c;
          lr = c;
          if (d_x != 11'(c) || d_y != 10'd0) bad_x++;
        end else if (d_x != 11'd0 || d_y != 10'd0) bad_x++;
        if (d_bn) begin
          if (fb < 0) fb = c;
          lb = c;
          xo = c - 3;
          xb = xo[7:0];
          if ({d_r, d_g, d_b} !== {xb, ~xb, 8'h00}) bad_d++;
        end
        if (d_hs) begin
          if (fh < 0) fh = c;
          lh = c;
        end
        if (d_vs) vs_hi++;
      end
      if (c == 40) chk("col37_r", d_r, 37);
      if (c == 1056) begin
        chk("l1_req", d_req, 1);
        chk("l1_x", d_x, 0);
        chk("l1_y", d_y, 1);
      end
      @(negedge clk);
    end
    chk("req_first", fr, 0);
    chk("req_last", lr, 799);
    chk("blank_first", fb, 3);
    chk("blank_last", lb, 802);
    chk("hs_first", fh, 843);
    chk("hs_last", lh, 970);
    chk("pix_xy", bad_x, 0);
    chk("ext_data", bad_d, 0);
    chk("vs_line0", vs_hi, 0);

    // enable low, select colour bars, restart
    d_en = 1'b0;
    d_sel = 2'd1;
    repeat (500) @(negedge clk);
    #1;
    chk("dis_req", d_req, 0);
    chk("dis_blank", d_bn, 0);
    chk("dis_hs", d_hs, 0);
    chk("dis_rgb", {d_r, d_g, d_b}, 0);
    @(negedge clk);
    fs_hi = 0;
    d_en = 1'b1;
    for (int c = 0; c < 810; c++) begin
      #1;
      if (c == 0) begin
        chk("en_req", d_req, 1);
        chk("en_x", d_x, 0);
        chk("en_y", d_y, 0);
      end
      if (c == 2) chk("en_blank2", d_bn, 0);
      if (c == 803) chk("bar_blank800", d_bn, 0);
      for (int k = 0; k < 8; k++)
        if (c == px[k] + 3) chk($sformatf("bar_x%0d", px[k]),
                                {d_r, d_g, d_b}, pe[k]);
      if (d_fs) fs_hi++;
      @(negedge clk);
    end
    chk("en_no_fs", fs_hi, 0);
    chk("en_fc", d_fc, 0);

    // small raster: frames, vsync, pattern switch at frame boundary
    fv = -1; lv = -1; f1 = -1; f2 = -1; nfs = 0;
    s_rst_n = 1'b1;
    for (int c = 0; c < 8600; c++) begin
      #1;
      if (c < 3680 && s_vs) begin
        if (fv < 0) fv = c;
        lv = c;
      end
      if (s_fs) begin
        nfs++;
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
      end
      if (c == 1600) s_sel = 2'd2;
      if (c == 2435) chk("mid_ext", {s_r, s_g, s_b}, 24'h20DF1E);
      if (c == 3683) chk("fs_blank", s_bn, 1);
      if (c == 3715) chk("chk_32_0", {s_r, s_g, s_b}, 24'hFFFFFF);
      if (c == 6243) chk("chk_0_32", {s_r, s_g, s_b}, 24'hFFFFFF);
      if (c == 6275) chk("chk_32_32", {s_r, s_g, s_b}, 24'h000000);
      if (c == 7364) chk("fc_two", s_fc, 2);
      @(negedge clk);
    end
    chk("vs_first", fv, 3283);
    chk("vs_last", lv, 3442);
    chk("fs_first", f1, 3683);
    chk("fs_second", f2, 7363);
    chk("fs_count", nfs, 2);

    // asynchronous reset mid-line 15 of the third frame
    #1;
    chk("pre_rst_rgb", {s_r, s_g, s_b}, 24'hFFFFFF);
    s_rst_n = 1'b0;
    #1;
    chk("arst_req", s_req, 0);
    chk("arst_blank", s_bn, 0);
    chk("arst_rgb", {s_r, s_g, s_b}, 0);
    chk("arst_vs_hs", {s_vs, s_hs}, 0);
    chk("arst_fc", s_fc, 0);
    @(negedge clk);
    s_rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c == 0) chk("rel_xy", {s_req, s_x, s_y}, {1'b1, 21'd0});
      if (c == 3) chk("rel_bn_fs", {s_bn, s_fs}, 2'b10);
      if (c == 35) chk("rel_chk", {s_r, s_g, s_b}, 24'hFFFFFF);
      @(negedge clk);
    end
    chk("rel_fc", s_fc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
